// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the RISC control FSM: states, memory commands,
// instruction fields, register selects, writeback sources and branch conditions.
package cpu_ctrl_pkg;

    typedef enum logic [4:0] {
        S_RESET    = 5'd0,
        S_IF1      = 5'd1,
        S_IF2      = 5'd2,
        S_UPD_PC   = 5'd3,
        S_DECODE   = 5'd4,
        S_GET_A    = 5'd5,
        S_GET_B    = 5'd6,
        S_ALU      = 5'd7,
        S_WB_C     = 5'd8,
        S_WB_IMM   = 5'd9,
        S_MEM_ADDR = 5'd10,
        S_LD_ADDR  = 5'd11,
        S_MEM_RD   = 5'd12,
        S_WB_MEM   = 5'd13,
        S_GET_D    = 5'd14,
        S_PASS_D   = 5'd15,
        S_MEM_WR   = 5'd16,
        S_BRANCH   = 5'd17,
        S_HALT     = 5'd18,
        S_FAULT    = 5'd19
    } state_t;

    localparam logic [1:0] M_NONE  = 2'b00;
    localparam logic [1:0] M_READ  = 2'b01;
    localparam logic [1:0] M_WRITE = 2'b10;

    localparam logic [2:0] OPC_BRANCH = 3'b001;
    localparam logic [2:0] OPC_LDR    = 3'b011;
    localparam logic [2:0] OPC_STR    = 3'b100;
    localparam logic [2:0] OPC_ALU    = 3'b101;
    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_HALT   = 3'b111;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [2:0] NSEL_RN = 3'b001;
    localparam logic [2:0] NSEL_RD = 3'b010;
    localparam logic [2:0] NSEL_RM = 3'b100;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM   = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    localparam logic [2:0] COND_AL = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_NE = 3'b010;
    localparam logic [2:0] COND_LT = 3'b011;
    localparam logic [2:0] COND_LE = 3'b100;

    function automatic logic is_wait_state(input state_t s);
        return (s == S_IF1) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

    // status is {N,V,Z}; reserved condition codes are simply never taken
    function automatic logic branch_taken(input logic [2:0] cond, input logic [2:0] status);
        logic n, v, z;
        n = status[2];
        v = status[1];
        z = status[0];
        case (cond)
            COND_AL: return 1'b1;
            COND_EQ: return z;
            COND_NE: return !z;
            COND_LT: return n ^ v;
            COND_LE: return (n ^ v) | z;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles in a memory-wait state and flags the
// last permitted cycle; MEM_TIMEOUT of 0 means the flag never rises.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (MEM_TIMEOUT != 0) && (cnt == LAST);

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control FSM for the RISC datapath: fetch, decode, execute,
// memory and writeback, with memory handshake timeout and sticky halt/fault.
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int ICNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        opcode,
    input  logic [1:0]        op,
    input  logic [2:0]        cond,
    input  logic [2:0]        status,
    input  logic              mem_ready,
    output logic [2:0]        nsel,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              bsel,
    output logic [1:0]        vsel,
    output logic              write,
    output logic              reset_pc,
    output logic              load_pc,
    output logic              PC_sel,
    output logic              addr_sel,
    output logic              load_ir,
    output logic              load_addr,
    output logic [1:0]        mem_cmd,
    output logic              halted,
    output logic              fault,
    output logic [ICNT_W-1:0] instr_count
);

    state_t state, state_next;
    logic   wait_expired;
    logic   retire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_RESET;
        end else begin
            state <= state_next;
        end
    end

    // Leaving a state clears the timer, so each wait starts from zero
    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (state_next != state),
        .en      (is_wait_state(state) && !mem_ready),
        .expired (wait_expired)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_RESET:  state_next = S_IF1;
            S_IF1: begin
                if (mem_ready)         state_next = S_IF2;
                else if (wait_expired) state_next = S_FAULT;
            end
            S_IF2:    state_next = S_UPD_PC;
            S_UPD_PC: state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OPC_MOV: begin
                        if (op == OP_MOV_IMM)      state_next = S_WB_IMM;
                        else if (op == OP_MOV_REG) state_next = S_GET_B;
                        else                       state_next = S_FAULT;
                    end
                    OPC_ALU, OPC_LDR, OPC_STR: state_next = S_GET_A;
                    OPC_BRANCH:                state_next = S_BRANCH;
                    OPC_HALT:                  state_next = S_HALT;
                    default:                   state_next = S_FAULT;
                endcase
            end
            S_GET_A:  state_next = (opcode == OPC_LDR || opcode == OPC_STR) ? S_MEM_ADDR : S_GET_B;
            S_GET_B:  state_next = S_ALU;
            S_ALU:    state_next = (opcode == OPC_ALU && op == OP_CMP) ? S_IF1 : S_WB_C;
            S_WB_C:   state_next = S_IF1;
            S_WB_IMM: state_next = S_IF1;
            S_MEM_ADDR: state_next = S_LD_ADDR;
            S_LD_ADDR: begin
                if (opcode == OPC_LDR)      state_next = S_MEM_RD;
                else if (opcode == OPC_STR) state_next = S_GET_D;
                else                        state_next = S_FAULT;
            end
            S_MEM_RD: begin
                if (mem_ready)         state_next = S_WB_MEM;
                else if (wait_expired) state_next = S_FAULT;
            end
            S_WB_MEM: state_next = S_IF1;
            S_GET_D:  state_next = S_PASS_D;
            S_PASS_D: state_next = S_MEM_WR;
            S_MEM_WR: begin
                if (mem_ready)         state_next = S_IF1;
                else if (wait_expired) state_next = S_FAULT;
            end
            S_BRANCH: state_next = S_IF1;
            S_HALT:   state_next = S_HALT;
            S_FAULT:  state_next = S_FAULT;
            default:  state_next = S_FAULT;
        endcase
    end

    // An instruction retires when its final state hands control back to fetch
    assign retire = (state_next == S_IF1) &&
                    ((state == S_WB_C)   || (state == S_WB_IMM) || (state == S_WB_MEM) ||
                     (state == S_MEM_WR) || (state == S_BRANCH) || (state == S_ALU));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_count <= '0;
        end else if (retire && (instr_count != {ICNT_W{1'b1}})) begin
            instr_count <= instr_count + ICNT_W'(1);
        end
    end

    always_comb begin
        nsel      = NSEL_RN;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        vsel      = VSEL_C;
        write     = 1'b0;
        reset_pc  = 1'b0;
        load_pc   = 1'b0;
        PC_sel    = 1'b0;
        addr_sel  = 1'b0;
        load_ir   = 1'b0;
        load_addr = 1'b0;
        mem_cmd   = M_NONE;
        halted    = 1'b0;
        fault     = 1'b0;
        case (state)
            S_RESET: begin
                reset_pc = 1'b1;
                load_pc  = 1'b1;
            end
            S_IF1: begin
                addr_sel = 1'b1;
                mem_cmd  = M_READ;
            end
            S_IF2: begin
                addr_sel = 1'b1;
                mem_cmd  = M_READ;
                load_ir  = 1'b1;
            end
            S_UPD_PC: load_pc = 1'b1;
            S_GET_A: begin
                nsel  = NSEL_RN;
                loada = 1'b1;
            end
            S_GET_B: begin
                nsel  = NSEL_RM;
                loadb = 1'b1;
            end
            S_ALU: begin
                loadc = 1'b1;
                asel  = (opcode == OPC_MOV && op == OP_MOV_REG) || (opcode == OPC_ALU && op == OP_MVN);
                loads = (opcode == OPC_ALU);
            end
            S_WB_C: begin
                nsel  = NSEL_RD;
                vsel  = VSEL_C;
                write = 1'b1;
            end
            S_WB_IMM: begin
                nsel  = NSEL_RN;
                vsel  = VSEL_IMM;
                write = 1'b1;
            end
            S_MEM_ADDR: begin
                bsel  = 1'b1;
                loadc = 1'b1;
            end
            S_LD_ADDR: load_addr = 1'b1;
            S_MEM_RD:  mem_cmd = M_READ;
            S_WB_MEM: begin
                mem_cmd = M_READ;
                nsel    = NSEL_RD;
                vsel    = VSEL_MDATA;
                write   = 1'b1;
            end
            S_GET_D: begin
                nsel  = NSEL_RD;
                loadb = 1'b1;
            end
            S_PASS_D: begin
                asel  = 1'b1;
                loadc = 1'b1;
            end
            S_MEM_WR: mem_cmd = M_WRITE;
            S_BRANCH: begin
                load_pc = branch_taken(cond, status);
                PC_sel  = branch_taken(cond, status);
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed scoreboard bench for cpu_ctrl_fsm: the stimulus pushes the expected
// outputs of each cycle, a monitor pops and compares on the falling edge.
module tb_cpu_ctrl_fsm;

    localparam int ICNT_W = 16;

    localparam int S_RESET = 0,  S_IF1 = 1,     S_IF2 = 2,     S_UPD = 3,   S_DEC = 4;
    localparam int S_GETA  = 5,  S_GETB = 6,    S_ALU = 7,     S_WBC = 8,   S_WBI = 9;
    localparam int S_MADDR = 10, S_LDADDR = 11, S_MRD = 12,    S_WBM = 13,  S_GETD = 14;
    localparam int S_PASSD = 15, S_MWR = 16,    S_BR = 17,     S_HALT = 18, S_FAULT = 19;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [2:0]        opcode = 3'b000;
    logic [1:0]        op = 2'b00;
    logic [2:0]        cond = 3'b000;
    logic [2:0]        status = 3'b000;
    logic              mem_ready = 1'b1;
    logic [2:0]        nsel;
    logic              loada, loadb, loadc, loads, asel, bsel;
    logic [1:0]        vsel;
    logic              write, reset_pc, load_pc, PC_sel, addr_sel, load_ir, load_addr;
    logic [1:0]        mem_cmd;
    logic              halted, fault;
    logic [ICNT_W-1:0] instr_count;

    cpu_ctrl_fsm #(.MEM_TIMEOUT(4), .ICNT_W(ICNT_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .op(op), .cond(cond),
        .status(status), .mem_ready(mem_ready), .nsel(nsel), .loada(loada),
        .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
        .vsel(vsel), .write(write), .reset_pc(reset_pc), .load_pc(load_pc),
        .PC_sel(PC_sel), .addr_sel(addr_sel), .load_ir(load_ir),
        .load_addr(load_addr), .mem_cmd(mem_cmd), .halted(halted), .fault(fault),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string             name;
        logic [21:0]       outs;
        logic [ICNT_W-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    logic [21:0] act;
    assign act = {nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, reset_pc,
                  load_pc, PC_sel, addr_sel, load_ir, load_addr, mem_cmd, halted, fault};

    // Expected output table per state; a/b carry the instruction-dependent bits
    // (BRANCH: a = taken; ALU: a = asel, b = loads)
    function automatic logic [21:0] expect_outs(input int st, input bit a, input bit b);
        logic [2:0] ns = 3'b001;
        logic la = 0, lb = 0, lc = 0, ls = 0, as = 0, bs = 0;
        logic [1:0] vs = 2'b00;
        logic wr = 0, rpc = 0, lpc = 0, ps = 0, ads = 0, lir = 0, ladr = 0;
        logic [1:0] mc = 2'b00;
        logic hl = 0, ft = 0;
        case (st)
            S_RESET:  begin rpc = 1; lpc = 1; end
            S_IF1:    begin ads = 1; mc = 2'b01; end
            S_IF2:    begin ads = 1; mc = 2'b01; lir = 1; end
            S_UPD:    lpc = 1;
            S_GETA:   begin ns = 3'b001; la = 1; end
            S_GETB:   begin ns = 3'b100; lb = 1; end
            S_ALU:    begin lc = 1; as = a; ls = b; end
            S_WBC:    begin ns = 3'b010; vs = 2'b00; wr = 1; end
            S_WBI:    begin ns = 3'b001; vs = 2'b10; wr = 1; end
            S_MADDR:  begin bs = 1; lc = 1; end
            S_LDADDR: ladr = 1;
            S_MRD:    mc = 2'b01;
            S_WBM:    begin mc = 2'b01; ns = 3'b010; vs = 2'b11; wr = 1; end
            S_GETD:   begin ns = 3'b010; lb = 1; end
            S_PASSD:  begin as = 1; lc = 1; end
            S_MWR:    mc = 2'b10;
            S_BR:     begin lpc = a; ps = a; end
            S_HALT:   hl = 1;
            S_FAULT:  ft = 1;
            default:  ;
        endcase
        return {ns, la, lb, lc, ls, as, bs, vs, wr, rpc, lpc, ps, ads, lir, ladr, mc, hl, ft};
    endfunction

    task automatic push_exp(input string nm, input int st, input int cnt, input bit a, input bit b);
        exp_t e;
        e.name = nm;
        e.outs = expect_outs(st, a, b);
        e.cnt  = cnt[ICNT_W-1:0];
        sb.push_back(e);
    endtask

    // Called just after a rising edge: record what this cycle must show, then advance
    task automatic step(input string nm, input int st, input int cnt, input bit a = 0, input bit b = 0);
        push_exp(nm, st, cnt, a, b);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string nm);
        reset = 1'b1;
        #1;
        push_exp(nm, S_RESET, 0, 0, 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic fetch(input int cnt);
        mem_ready = 1'b1;
        step("if1", S_IF1, cnt);
        step("if2", S_IF2, cnt);
        step("upd_pc", S_UPD, cnt);
        step("decode", S_DEC, cnt);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                tests++;
                if (act !== e.outs || instr_count !== e.cnt) begin
                    fails++;
                    $display("FAIL %s: got outs=%06h count=%0d, want outs=%06h count=%0d",
                             e.name, act, instr_count, e.outs, e.cnt);
                end
            end
        end
    end

    initial begin : stimulus
        do_reset("reset_state");
        step("reset_release", S_RESET, 0);

        // MOV R1,#5
        opcode = 3'b110; op = 2'b10;
        fetch(0);
        step("mov_wb_imm", S_WBI, 0);

        // LDR with three not-ready cycles
        opcode = 3'b011; op = 2'b00;
        fetch(1);
        step("ldr_get_a", S_GETA, 1);
        step("ldr_mem_addr", S_MADDR, 1);
        step("ldr_ld_addr", S_LDADDR, 1);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("ldr_mem_rd_wait", S_MRD, 1);
        mem_ready = 1'b1;
        step("ldr_mem_rd_go", S_MRD, 1);
        step("ldr_wb_mem", S_WBM, 1);

        // CMP: sets status, no writeback, still retires
        opcode = 3'b101; op = 2'b01;
        fetch(2);
        step("cmp_get_a", S_GETA, 2);
        step("cmp_get_b", S_GETB, 2);
        step("cmp_alu", S_ALU, 2, 0, 1);

        // BEQ taken, BEQ not taken, reserved cond, BLT taken
        opcode = 3'b001; op = 2'b00; cond = 3'b001; status = 3'b001;
        fetch(3);
        step("beq_taken", S_BR, 3, 1);
        status = 3'b000;
        fetch(4);
        step("beq_not_taken", S_BR, 4, 0);
        cond = 3'b110; status = 3'b001;
        fetch(5);
        step("bcond110_never", S_BR, 5, 0);
        cond = 3'b011; status = 3'b100;
        fetch(6);
        step("blt_taken", S_BR, 6, 1);

        // MVN: asel zeroes A, loads set, writeback of C
        opcode = 3'b101; op = 2'b11;
        fetch(7);
        step("mvn_get_a", S_GETA, 7);
        step("mvn_get_b", S_GETB, 7);
        step("mvn_alu", S_ALU, 7, 1, 1);
        step("mvn_wb_c", S_WBC, 7);

        // STR with one not-ready cycle in MEM_WR
        opcode = 3'b100; op = 2'b00;
        fetch(8);
        step("str_get_a", S_GETA, 8);
        step("str_mem_addr", S_MADDR, 8);
        step("str_ld_addr", S_LDADDR, 8);
        step("str_get_d", S_GETD, 8);
        step("str_pass_d", S_PASSD, 8);
        mem_ready = 1'b0;
        step("str_mem_wr_wait", S_MWR, 8);
        mem_ready = 1'b1;
        step("str_mem_wr_go", S_MWR, 8);

        // Fetch timeout: four not-ready cycles in IF1, then sticky FAULT
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) step("if1_timeout_wait", S_IF1, 9);
        step("timeout_fault", S_FAULT, 9);
        mem_ready = 1'b1;
        step("fault_sticky", S_FAULT, 9);
        step("fault_sticky2", S_FAULT, 9);
        do_reset("reset_from_fault");
        step("reset_after_fault", S_RESET, 0);

        // MOV then STR aborted by reset inside MEM_WR
        opcode = 3'b110; op = 2'b10;
        fetch(0);
        step("mov2_wb_imm", S_WBI, 0);
        opcode = 3'b100; op = 2'b00;
        fetch(1);
        step("str2_get_a", S_GETA, 1);
        step("str2_mem_addr", S_MADDR, 1);
        step("str2_ld_addr", S_LDADDR, 1);
        step("str2_get_d", S_GETD, 1);
        step("str2_pass_d", S_PASSD, 1);
        mem_ready = 1'b0;
        step("str2_mem_wr_wait", S_MWR, 1);
        step("str2_mem_wr_wait2", S_MWR, 1);
        do_reset("reset_mid_mem_wr");
        step("reset_after_abort", S_RESET, 0);

        // HALT is absorbing
        opcode = 3'b111; op = 2'b00;
        fetch(0);
        for (int i = 0; i < 3; i++) step("halt_sticky", S_HALT, 0);
        do_reset("reset_from_halt");
        step("reset_after_halt", S_RESET, 0);

        // Undefined opcode faults at decode
        opcode = 3'b010; op = 2'b00;
        fetch(0);
        step("illegal_fault", S_FAULT, 0);
        step("illegal_fault_sticky", S_FAULT, 0);

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
